// File: rtl/mig1_fetch_queue.sv
// mig1_fetch_queue: instruction prefetch queue with redirect flush and in-flight response drop
// Ports: clk/reset; redirect+redirect_pc restart fetch; mem_req/mem_addr/mem_gnt issue fetches;
// mem_rvalid/mem_rdata return words in request order; insn_valid/insn/insn_pc/insn_ready hand out the head.
module mig1_fetch_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [INSN_WIDTH-1:0] mem_rdata,
  output logic                  insn_valid,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  input  logic                  insn_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, new_pc;
  logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
  logic [INSN_WIDTH-1:0] insn_mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count, outstanding, drop;
  logic issue, push, pop;
  always_comb begin
    new_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    // credit covers buffered words plus every in-flight fetch, so a push can never overflow
    mem_req = !reset && !redirect && (({1'b0, count} + {1'b0, outstanding}) < CAP);
    mem_addr = fetch_pc;
    issue = mem_req && mem_gnt;
    push = !reset && !redirect && mem_rvalid && (drop == '0);
    insn_valid = count != '0;
    pop = insn_valid && insn_ready && !redirect;
    insn = insn_mem[rd];
    insn_pc = pc_mem[rd];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      rd <= '0;
      wr <= '0;
      count <= '0;
      outstanding <= '0;
      drop <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(mem_rvalid);
      if (redirect) begin
        fetch_pc <= new_pc;
        resp_pc <= new_pc;
        rd <= '0;
        wr <= '0;
        count <= '0;
        // every fetch still in flight belongs to the old stream; stale ones already in drop are among them
        drop <= outstanding - CW'(mem_rvalid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (push) begin
          resp_pc <= resp_pc + ADDR_WIDTH'(4);
          wr <= wr + PW'(1);
        end
        if (pop) rd <= rd + PW'(1);
        if (mem_rvalid && drop != '0) drop <= drop - CW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr] <= resp_pc;
      insn_mem[wr] <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mig1_fetch_queue.sv
// tb_mig1_fetch_queue: scoreboard bench for mig1_fetch_queue with a pipelined in-order memory model
module tb_mig1_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int DEPTH = 4;
  typedef struct { int due; logic [31:0] data; } resp_t;
  typedef struct { logic [31:0] pc; logic [31:0] w; } exp_t;
  logic clk = 0, reset = 1, redirect = 0, mem_gnt = 0, mem_rvalid = 0, insn_ready = 0;
  logic [31:0] redirect_pc = '0, mem_rdata = '0;
  logic mem_req, insn_valid;
  logic [31:0] mem_addr, insn, insn_pc;
  int errors = 0, checks = 0, consumed = 0, grants = 0, cyc = 0, last_due = 0, c0 = 0;
  int gnt_pct = 100, rdy_pct = 100, lat_min = 1, lat_max = 1;
  logic prev_flush = 0;
  logic [31:0] exp_fetch = RESET_PC;
  resp_t mq[$];
  exp_t sb[$];

  mig1_fetch_queue #(.ADDR_WIDTH(32), .INSN_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .insn_valid(insn_valid), .insn(insn), .insn_pc(insn_pc), .insn_ready(insn_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // one clock: drive inputs for the coming edge, then update memory and reference model
  task automatic step(input logic r, input logic [31:0] rp, input logic rst);
    int d;
    @(negedge clk);
    reset = rst;
    redirect = r;
    redirect_pc = rp;
    mem_gnt = $urandom_range(99) < gnt_pct;
    insn_ready = $urandom_range(99) < rdy_pct;
    mem_rvalid = !rst && mq.size() != 0 && mq[0].due <= cyc;
    mem_rdata = mem_rvalid ? mq[0].data : $urandom;
    #1;
    if (prev_flush) chk("flush_empty", 32'(insn_valid), 32'd0);
    prev_flush = rst || r;
    if (rst) begin
      mq.delete();
      sb.delete();
      exp_fetch = RESET_PC;
    end else begin
      if (mem_rvalid) void'(mq.pop_front());
      if (r) begin
        sb.delete();
        exp_fetch = {rp[31:2], 2'b00};
      end
      if (mem_req && mem_gnt) begin
        chk("fetch_addr", mem_addr, exp_fetch);
        d = cyc + int'($urandom_range(lat_max, lat_min));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        mq.push_back('{d, word(mem_addr)});
        sb.push_back('{exp_fetch, word(exp_fetch)});
        exp_fetch += 32'd4;
        grants++;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0);
  endtask

  // monitor: every consumed head must be the next expected instruction of the current stream
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset && !redirect && insn_valid && insn_ready) begin
      consumed++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_insn: got pc %h with nothing expected", insn_pc);
      end else begin
        e = sb.pop_front();
        chk("insn_pc", insn_pc, e.pc);
        chk("insn", insn, e.w);
      end
    end
  end

  initial begin
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, RESET_PC);
    step(1'b0, 32'h0, 1'b0);
    chk("first_req", 32'(mem_req), 32'd1);
    chk("first_addr", mem_addr, RESET_PC);
    run(2);
    c0 = consumed;
    run(20);
    chk("throughput", 32'(consumed - c0), 32'd20);

    rdy_pct = 0;
    step(1'b0, 32'h0, 1'b1);
    grants = 0;
    run(10);
    chk("fill_grants", 32'(grants), 32'd4);
    chk("fill_req", 32'(mem_req), 32'd0);
    chk("fill_valid", 32'(insn_valid), 32'd1);
    rdy_pct = 100;
    run(10);

    lat_min = 3;
    lat_max = 3;
    step(1'b0, 32'h0, 1'b1);
    run(3);
    step(1'b1, 32'h100, 1'b0);
    chk("redir_req", 32'(mem_req), 32'd0);
    step(1'b0, 32'h0, 1'b0);
    chk("redir_req2", 32'(mem_req), 32'd1);
    chk("redir_addr", mem_addr, 32'h100);
    c0 = consumed;
    run(15);
    chk("redir_progress", 32'(consumed - c0 > 0), 32'd1);

    lat_min = 1;
    lat_max = 1;
    step(1'b1, 32'h203, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("align_addr", mem_addr, 32'h200);
    run(8);
    step(1'b1, 32'hFFFF_FFF8, 1'b0);
    run(12);

    rdy_pct = 0;
    run(10);
    chk("full_valid", 32'(insn_valid), 32'd1);
    chk("full_req", 32'(mem_req), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("rstfull_req", 32'(mem_req), 32'd0);
    rdy_pct = 100;
    step(1'b0, 32'h0, 1'b0);
    chk("restart_req", 32'(mem_req), 32'd1);
    chk("restart_addr", mem_addr, RESET_PC);
    run(10);

    gnt_pct = 70;
    rdy_pct = 60;
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = int'($urandom_range(999));
      if (p < 5) step(1'b0, 32'h0, 1'b1);
      else if (p < 60) step(1'b1, (p < 15) ? 32'hFFFF_FFF0 | 32'($urandom_range(15)) : $urandom, 1'b0);
      else step(1'b0, 32'h0, 1'b0);
    end
    gnt_pct = 100;
    rdy_pct = 100;
    run(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
